mem_arbiter: RTL

- Arbiter sharing a single unified memory port between the instruction fetch path (I) and the load/store data path (D).
- Sits between the IFU/datapath and the shared memory model.
- Serialises requests, latches request fields, handles a variable-latency memory handshake and returns registered responses with a one-cycle ack.
- Uses round-robin on conflict so neither side starves; counts conflicts for performance tests.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch (I) and data (D)
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ack,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_be,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ack,
  output logic [CNT_W-1:0]      conflicts
);

  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;

  state_t                state_q, state_d;
  logic                  m_req_q, m_req_d;
  logic                  m_we_q, m_we_d;
  logic [ADDR_W-1:0]     m_addr_q, m_addr_d;
  logic [DATA_W-1:0]     m_wdata_q, m_wdata_d;
  logic [DATA_W/8-1:0]   m_be_q, m_be_d;
  logic                  i_ack_q, i_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic [DATA_W-1:0]     i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]      conflicts_q, conflicts_d;
  logic                  last_q, last_d;  // 1 = D was granted last
  logic                  i_elig, d_elig, grant_i, grant_d;

  always_comb begin
    state_d     = state_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_be_d      = m_be_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    conflicts_d = conflicts_q;
    last_d      = last_q;
    i_elig      = 1'b0;
    d_elig      = 1'b0;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    case (state_q)
      SERVE_I: begin
        if (m_ack) begin
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          i_rdata_d = m_rdata;
          i_ack_d   = 1'b1;
          state_d   = RESP_I;
        end
      end
      SERVE_D: begin
        if (m_ack) begin
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          if (!m_we_q) d_rdata_d = m_rdata;
          d_ack_d = 1'b1;
          state_d = RESP_D;
        end
      end
      default: begin
        // The side acked this cycle still holds req high, so it sits out this decision.
        i_elig = i_req && (state_q != RESP_I);
        d_elig = d_req && (state_q != RESP_D);
        if (i_elig && d_elig) begin
          grant_i = last_q;
          grant_d = !last_q;
          if (conflicts_q != {CNT_W{1'b1}})
            conflicts_d = conflicts_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          grant_i = i_elig;
          grant_d = d_elig;
        end

        if (grant_i) begin
          state_d   = SERVE_I;
          last_d    = 1'b0;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          m_be_d    = '1;
        end else if (grant_d) begin
          state_d   = SERVE_D;
          last_d    = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_be_d    = d_be;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_be_q      <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      conflicts_q <= '0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_be_q      <= m_be_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      conflicts_q <= conflicts_d;
      last_q      <= last_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_be      = m_be_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign conflicts = conflicts_q;

endmodule
